axis_adder_stream_checker: RTL and testbench
============================================

Name: axis_adder_stream_checker

Overview:
- AXI4-Stream sink that terminates the output stream of the pipelined adder kernel and checks every beat against a locally generated expected pattern: the generator sequence plus the control constant.
- Applies a programmable tready back-pressure pattern so the upstream FIFO full and empty paths are exercised.
- Reports beat count, error count, first-error location, and pass/done status to the control block.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, stream data width; must be a multiple of C_ADDER_BIT_WIDTH.
- C_ADDER_BIT_WIDTH, 32, lane width. LP_NUM_LANES = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_areset  in  1  asynchronous, active-high reset.
- ctrl_start  in  1  one-cycle start pulse.
- ctrl_seed  in  C_ADDER_BIT_WIDTH  value of lane 0 of beat 0 before the constant is added.
- ctrl_constant  in  C_ADDER_BIT_WIDTH  adder constant.
- ctrl_num_beats  in  32  beats expected in the run.
- ctrl_tready_mask  in  8  back-pressure pattern; bit k enables tready in phase k.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8
- s_axis_tlast  in  1
- status_busy  out  1  high while in RUN or CHECK.
- status_done  out  1  high in DONE.
- status_pass  out  1  high in DONE when err_count is 0.
- status_beat_count  out  32  beats accepted.
- status_err_count  out  32  beats with at least one error; saturates at 2^32-1.
- status_first_err_beat  out  32  index of the first bad beat; 0xFFFFFFFF if none.

Behaviour:
- Reset values: s_axis_tready, status_busy, status_done and status_pass are 0. beat_count and err_count are 0. first_err_beat is 0xFFFFFFFF. FSM is in IDLE.
- ctrl_* inputs are latched on ctrl_start. They are ignored at all other times.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE or DONE with ctrl_start:
  - clear all counters and set first_err to 0xFFFFFFFF;
  - go to RUN, or go directly to DONE with pass=1 if ctrl_num_beats is 0.
- ctrl_start while in RUN or CHECK is ignored.
- RUN back-pressure:
  - a 3-bit phase counter starts at 0 on entry to RUN and increments every RUN cycle, wrapping 7 to 0;
  - s_axis_tready is registered and equals ctrl_tready_mask[phase];
  - a mask of 0x00 stalls forever, which is legal;
  - tready is 0 in IDLE, CHECK and DONE.
- Handshake: a beat is accepted when tvalid and tready are both high in the same cycle. Nothing else is sampled.
- Expected data for accepted beat b, lane i: seed + constant + b*LP_NUM_LANES + i, modulo 2^C_ADDER_BIT_WIDTH.
  - Generated from a base register that starts at seed+constant and adds LP_NUM_LANES per accepted beat.
  - No multipliers.
- Pipeline: the accepted beat and its expected vector are registered in stage 1. Comparison happens in stage 2, one cycle later. Counters update at the end of stage 2.
- A beat is bad if any of the following holds:
  - any lane mismatches;
  - tkeep is not all ones;
  - tlast differs from (b == num_beats-1).
- A bad beat increments err_count by exactly 1, regardless of how many faults it has. first_err_beat is captured only once per run.
- beat_count increments at stage 1.
- On accepting beat num_beats-1: go to CHECK and drop tready on the next cycle. When stage 2 completes, go to DONE; status_done asserts exactly 2 cycles after the final handshake cycle.
- Early tlast, before beat num_beats-1, is counted as an error. The run continues.
- Extra beats after num_beats are never accepted, because tready is 0.
- status_pass is valid only while status_done is 1; it is 0 otherwise.
- Asynchronous reset in any state returns every output to its reset value immediately. An in-flight pipeline beat is discarded.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2-bit, four states);
  - LP_NUM_LANES;
  - the constant FIRST_ERR_NONE = 0xFFFFFFFF.
- One sub-module, axis_adder_lane_compare:
  - registered comparison of one C_AXIS_TDATA_WIDTH vector against the expected vector;
  - 1-cycle latency;
  - outputs a single mismatch bit.

Test Plan:
- Clean run: seed 0, constant 5, num_beats 4, mask 0xFF, source always valid with correct data (beat 0 lane 0 = 5, beat 3 lane 15 = 68), tlast on beat 3. Expect done 2 cycles after the 4th handshake, pass=1, beat_count=4, err_count=0, first_err=0xFFFFFFFF.
- Corrupt data: same run with beat 2 lane 7 = 0. Expect err_count=1, first_err_beat=2, pass=0.
- Throttle: mask 0x55, num_beats 8, source always valid. Expect tready toggling every cycle, 8 handshakes in 16 RUN cycles, pass=1.
- Wrap and saturation:
  - Seed 0xFFFFFFF0, constant 0x20, 2 beats. Expect lane 0 = 0x10, correct wrap, pass=1.
  - err_count saturation: force err_count to 0xFFFFFFFF before a bad beat; it stays at 0xFFFFFFFF.
- Protocol faults, num_beats 3:
  - tlast on beat 1, tkeep 0 on beat 2. Expect err_count=2, first_err=1, no 4th beat accepted.
  - num_beats 0: done and pass asserted one cycle after start, tready never high.
- Reset mid-run: assert s_axis_areset after 2 of 5 beats. Expect tready, busy and counters immediately 0 and IDLE. A new start then completes a clean run.

Source files
------------

// File: rtl/axis_adder_stream_checker_pkg.sv
// Shared constants for the adder stream checker: FSM encoding, lane count and
// the "no error seen" marker for the first-error register.
package axis_adder_stream_checker_pkg;

    localparam int unsigned C_DEF_ADDER_BIT_WIDTH = 32;
    localparam int unsigned LP_NUM_LANES          = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] FIRST_ERR_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/axis_adder_lane_compare.sv
// Registered whole-vector compare of a beat against its expected lanes;
// one cycle of latency, one mismatch bit out.
module axis_adder_lane_compare #(
    parameter int unsigned C_DATA_WIDTH = 512
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [C_DATA_WIDTH-1:0] i_data,
    input  logic [C_DATA_WIDTH-1:0] i_expected,
    output logic                    o_mismatch
);

    logic r_mismatch;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= i_en && (i_data != i_expected);
        end
    end

    assign o_mismatch = r_mismatch;

endmodule

// File: rtl/axis_adder_stream_checker.sv
// AXI4-Stream sink that checks each beat of the adder output against
// seed + constant + running lane index, with programmable tready back-pressure.
module axis_adder_stream_checker
    import axis_adder_stream_checker_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = LP_NUM_LANES * C_DEF_ADDER_BIT_WIDTH,
    parameter int unsigned C_ADDER_BIT_WIDTH  = C_DEF_ADDER_BIT_WIDTH
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_areset,
    input  logic                            ctrl_start,
    input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_seed,
    input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant,
    input  logic [31:0]                     ctrl_num_beats,
    input  logic [7:0]                      ctrl_tready_mask,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            status_busy,
    output logic                            status_done,
    output logic                            status_pass,
    output logic [31:0]                     status_beat_count,
    output logic [31:0]                     status_err_count,
    output logic [31:0]                     status_first_err_beat
);

    localparam int unsigned LP_LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
    localparam logic [C_ADDER_BIT_WIDTH-1:0] LP_BASE_STEP = C_ADDER_BIT_WIDTH'(LP_LANES);

    logic [1:0]                    r_state;
    logic [1:0]                    w_state_next;
    logic [2:0]                    r_phase;
    logic [2:0]                    w_phase_next;
    logic [7:0]                    r_mask;
    logic [7:0]                    w_mask_next;
    logic                          r_tready;
    logic [31:0]                   r_num_beats;
    logic [C_ADDER_BIT_WIDTH-1:0]  r_base;
    logic [31:0]                   r_beat_count;
    logic [31:0]                   r_err_count;
    logic [31:0]                   r_first_err;
    logic                          r_s1_valid;
    logic                          r_s1_keep_bad;
    logic                          r_s1_last_bad;
    logic [31:0]                   r_s1_idx;
    logic                          w_start;
    logic                          w_hs;
    logic                          w_is_final;
    logic                          w_mismatch;
    logic                          w_bad;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_expected;

    assign w_start    = ctrl_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hs       = s_axis_tvalid && r_tready;
    assign w_is_final = (r_beat_count == r_num_beats - 32'd1);
    assign w_bad      = r_s1_valid && (w_mismatch || r_s1_keep_bad || r_s1_last_bad);

    // Lane i of the current beat is base + i; base steps by the lane count per beat.
    for (genvar g = 0; g < LP_LANES; g++) begin : g_expected
        assign w_expected[g*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
            r_base + C_ADDER_BIT_WIDTH'(g);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (ctrl_start) begin
                    w_state_next = (ctrl_num_beats == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN:   if (w_hs && w_is_final) w_state_next = ST_CHECK;
            ST_CHECK: if (r_s1_valid) w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_phase_next = (r_state == ST_RUN) ? r_phase + 3'd1 : 3'd0;
    assign w_mask_next  = w_start ? ctrl_tready_mask : r_mask;

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_state     <= ST_IDLE;
            r_phase     <= 3'd0;
            r_mask      <= 8'd0;
            r_tready    <= 1'b0;
            r_num_beats <= 32'd0;
            r_base      <= '0;
        end else begin
            r_state  <= w_state_next;
            r_phase  <= w_phase_next;
            r_mask   <= w_mask_next;
            r_tready <= (w_state_next == ST_RUN) && w_mask_next[w_phase_next];
            if (w_start) begin
                r_num_beats <= ctrl_num_beats;
                r_base      <= ctrl_seed + ctrl_constant;
            end else if (w_hs) begin
                r_base <= r_base + LP_BASE_STEP;
            end
        end
    end

    // Stage 1: handshake flags and beat index alongside the registered compare.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_s1_valid    <= 1'b0;
            r_s1_keep_bad <= 1'b0;
            r_s1_last_bad <= 1'b0;
            r_s1_idx      <= 32'd0;
        end else begin
            r_s1_valid    <= w_hs;
            r_s1_keep_bad <= (s_axis_tkeep != '1);
            r_s1_last_bad <= (s_axis_tlast != w_is_final);
            r_s1_idx      <= r_beat_count;
        end
    end

    axis_adder_lane_compare #(
        .C_DATA_WIDTH (C_AXIS_TDATA_WIDTH)
    ) u_compare (
        .i_clk      (s_axis_aclk),
        .i_rst      (s_axis_areset),
        .i_en       (w_hs),
        .i_data     (s_axis_tdata),
        .i_expected (w_expected),
        .o_mismatch (w_mismatch)
    );

    // Stage 2: one error per bad beat, saturating; first error captured once.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_beat_count <= 32'd0;
            r_err_count  <= 32'd0;
            r_first_err  <= FIRST_ERR_NONE;
        end else if (w_start) begin
            r_beat_count <= 32'd0;
            r_err_count  <= 32'd0;
            r_first_err  <= FIRST_ERR_NONE;
        end else begin
            if (w_hs) begin
                r_beat_count <= r_beat_count + 32'd1;
            end
            if (w_bad) begin
                if (r_err_count != 32'hFFFF_FFFF) begin
                    r_err_count <= r_err_count + 32'd1;
                end
                if (r_first_err == FIRST_ERR_NONE) begin
                    r_first_err <= r_s1_idx;
                end
            end
        end
    end

    assign s_axis_tready         = r_tready;
    assign status_busy           = (r_state == ST_RUN) || (r_state == ST_CHECK);
    assign status_done           = (r_state == ST_DONE);
    assign status_pass           = (r_state == ST_DONE) && (r_err_count == 32'd0);
    assign status_beat_count     = r_beat_count;
    assign status_err_count      = r_err_count;
    assign status_first_err_beat = r_first_err;

endmodule

// File: tb/tb_axis_adder_stream_checker.sv
// Bench for the adder stream checker: directed table of runs, random runs scored
// by a per-beat fault model, plus reset-mid-run and err_count saturation.
module tb_axis_adder_stream_checker;

    localparam int unsigned TW    = 512;
    localparam int unsigned LW    = 32;
    localparam int unsigned LANES = TW / LW;
    localparam int unsigned KW    = TW / 8;
    localparam int          MAXB  = 16;

    typedef struct {
        logic [31:0] seed;
        logic [31:0] cnst;
        int          nb;
        logic [7:0]  mask;
        int          bad_beat;
        int          bad_lane;
        logic [31:0] bad_xor;
        int          last_flip_beat;
        int          keep_bad_beat;
        bit          force_sat;
        logic [31:0] exp_err;
        logic [31:0] exp_first;
        bit          exp_pass;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          ctrl_start;
    logic [31:0]   ctrl_seed;
    logic [31:0]   ctrl_constant;
    logic [31:0]   ctrl_num_beats;
    logic [7:0]    ctrl_tready_mask;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [TW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          status_busy;
    logic          status_done;
    logic          status_pass;
    logic [31:0]   status_beat_count;
    logic [31:0]   status_err_count;
    logic [31:0]   status_first_err_beat;

    int checks   = 0;
    int failures = 0;

    logic [31:0]   cur_seed;
    logic [31:0]   cur_cnst;
    int            cur_nb;
    int            f_lane  [MAXB];
    logic [31:0]   f_xor   [MAXB];
    bit            f_last  [MAXB];
    logic [KW-1:0] f_keepv [MAXB];

    vec_t tbl [8];

    axis_adder_stream_checker #(
        .C_AXIS_TDATA_WIDTH (TW),
        .C_ADDER_BIT_WIDTH  (LW)
    ) dut (
        .s_axis_aclk           (clk),
        .s_axis_areset         (rst),
        .ctrl_start            (ctrl_start),
        .ctrl_seed             (ctrl_seed),
        .ctrl_constant         (ctrl_constant),
        .ctrl_num_beats        (ctrl_num_beats),
        .ctrl_tready_mask      (ctrl_tready_mask),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tready         (s_axis_tready),
        .s_axis_tdata          (s_axis_tdata),
        .s_axis_tkeep          (s_axis_tkeep),
        .s_axis_tlast          (s_axis_tlast),
        .status_busy           (status_busy),
        .status_done           (status_done),
        .status_pass           (status_pass),
        .status_beat_count     (status_beat_count),
        .status_err_count      (status_err_count),
        .status_first_err_beat (status_first_err_beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_faults();
        for (int b = 0; b < MAXB; b++) begin
            f_lane[b]  = -1;
            f_xor[b]   = 32'd0;
            f_last[b]  = 1'b0;
            f_keepv[b] = '1;
        end
    endtask

    // Source model: lane i of beat b is seed + constant + b*LANES + i, plus injected faults.
    task automatic drive_beat(input int b);
        for (int i = 0; i < int'(LANES); i++) begin
            logic [31:0] v;
            v = cur_seed + cur_cnst + 32'(b * int'(LANES) + i);
            if (b < MAXB && f_lane[b] == i) v = v ^ f_xor[b];
            s_axis_tdata[i*LW +: LW] = v;
        end
        s_axis_tkeep = (b < MAXB) ? f_keepv[b] : '1;
        s_axis_tlast = (b == cur_nb - 1);
        if (b < MAXB && f_last[b]) s_axis_tlast = !s_axis_tlast;
    endtask

    task automatic run_vec(input vec_t v, input bit poke_start);
        int  h;
        int  hs;
        int  b;
        int  budget;
        bit  final_seen;
        bit  acc;
        bit  done_seen;
        cur_seed = v.seed;
        cur_cnst = v.cnst;
        cur_nb   = v.nb;
        @(posedge clk); #1;
        ctrl_seed        = v.seed;
        ctrl_constant    = v.cnst;
        ctrl_num_beats   = 32'(v.nb);
        ctrl_tready_mask = v.mask;
        ctrl_start       = 1'b1;
        b = 0;
        drive_beat(0);
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        ctrl_start       = 1'b0;
        ctrl_seed        = $urandom;
        ctrl_constant    = $urandom;
        ctrl_num_beats   = $urandom;
        ctrl_tready_mask = 8'($urandom);
        h          = -2;
        hs         = 0;
        final_seen = (v.nb == 0);
        done_seen  = 1'b0;
        budget     = 10 * v.nb + 20;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (status_done) begin
                chk("done_latency", 32'(k - h), 32'd2);
                done_seen = 1'b1;
                break;
            end
            if (k == 0) begin
                chk("busy_in_run", 32'(status_busy), 32'd1);
                chk("pass_low_in_run", 32'(status_pass), 32'd0);
                if (v.force_sat) force dut.r_err_count = 32'hFFFF_FFFF;
            end
            if (!final_seen) chk("tready_phase", 32'(s_axis_tready), 32'(v.mask[k % 8]));
            else if (k == h + 1) chk("tready_drop", 32'(s_axis_tready), 32'd0);
            acc = s_axis_tvalid && s_axis_tready;
            if (acc) begin
                hs++;
                if (b == v.nb - 1) begin
                    final_seen = 1'b1;
                    h = k;
                end
            end
            @(posedge clk); #1;
            if (k == 0 && v.force_sat) release dut.r_err_count;
            if (acc) begin
                b++;
                drive_beat(b);
            end
            if (poke_start) ctrl_start = (k == 1 && v.nb >= 3);
        end
        ctrl_start = 1'b0;
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        chk("beat_count", status_beat_count, 32'(v.nb));
        chk("err_count", status_err_count, v.exp_err);
        chk("first_err", status_first_err_beat, v.exp_first);
        chk("pass", 32'(status_pass), 32'(v.exp_pass));
        chk("busy_after_done", 32'(status_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tready_after_done", 32'(s_axis_tready), 32'd0);
            if (s_axis_tvalid && s_axis_tready) hs++;
        end
        chk("handshakes", 32'(hs), 32'(v.nb));
        s_axis_tvalid = 1'b0;
    endtask

    task automatic load_faults(input vec_t v);
        clear_faults();
        if (v.bad_beat >= 0) begin
            f_lane[v.bad_beat] = v.bad_lane;
            f_xor[v.bad_beat]  = v.bad_xor;
        end
        if (v.last_flip_beat >= 0) f_last[v.last_flip_beat] = 1'b1;
        if (v.keep_bad_beat >= 0) f_keepv[v.keep_bad_beat] = '0;
    endtask

    initial begin
        vec_t rv;
        int   hs;
        int   b;
        bit   acc;
        rst = 1'b1;
        ctrl_start = 1'b0;
        ctrl_seed = 32'd0;
        ctrl_constant = 32'd0;
        ctrl_num_beats = 32'd0;
        ctrl_tready_mask = 8'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;

        // seed cnst nb mask bad_beat bad_lane bad_xor last_flip keep_bad sat exp_err exp_first pass
        tbl[0] = '{32'h0, 32'h5, 4, 8'hFF, -1, 0, 32'h0, -1, -1, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1};
        tbl[1] = '{32'h0, 32'h5, 4, 8'hFF, 2, 7, 32'd44, -1, -1, 1'b0, 32'd1, 32'd2, 1'b0};
        tbl[2] = '{32'h3, 32'h7, 8, 8'h55, -1, 0, 32'h0, -1, -1, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1};
        tbl[3] = '{32'hFFFF_FFF0, 32'h20, 2, 8'hFF, -1, 0, 32'h0, -1, -1, 1'b0, 32'd0,
                   32'hFFFF_FFFF, 1'b1};
        tbl[4] = '{32'h9, 32'h1, 3, 8'hFF, -1, 0, 32'h0, 1, 2, 1'b0, 32'd2, 32'd1, 1'b0};
        tbl[5] = '{32'h1, 32'h2, 0, 8'hFF, -1, 0, 32'h0, -1, -1, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{32'h0, 32'h0, 2, 8'hFF, 1, 0, 32'h1, -1, -1, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0};
        tbl[7] = '{32'd100, 32'h1, 3, 8'h81, 2, 15, 32'hFFFF_0000, 2, -1, 1'b0, 32'd1, 32'd2, 1'b0};

        #3;
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_busy", 32'(status_busy), 32'd0);
        chk("rst_done", 32'(status_done), 32'd0);
        chk("rst_pass", 32'(status_pass), 32'd0);
        chk("rst_beat_count", status_beat_count, 32'd0);
        chk("rst_err_count", status_err_count, 32'd0);
        chk("rst_first_err", status_first_err_beat, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            load_faults(tbl[t]);
            run_vec(tbl[t], 1'b0);
        end

        // Random runs, scored by counting faulty beats in the injected fault set.
        for (int r = 0; r < 10; r++) begin
            clear_faults();
            rv = tbl[0];
            rv.seed = $urandom;
            rv.cnst = $urandom;
            rv.nb   = int'($urandom_range(1, 10));
            rv.mask = 8'($urandom_range(1, 255));
            rv.exp_err   = 32'd0;
            rv.exp_first = 32'hFFFF_FFFF;
            for (int bb = 0; bb < rv.nb; bb++) begin
                int sel;
                sel = int'($urandom_range(0, 7));
                if (sel == 0 || sel == 3) begin
                    f_lane[bb] = int'($urandom_range(0, LANES - 1));
                    f_xor[bb]  = 32'($urandom) | 32'h1;
                end
                if (sel == 1 || sel == 3) f_last[bb] = 1'b1;
                if (sel == 2) f_keepv[bb] = ~(KW'(1) << $urandom_range(0, KW - 1));
                if (sel <= 3) begin
                    rv.exp_err = rv.exp_err + 32'd1;
                    if (rv.exp_first == 32'hFFFF_FFFF) rv.exp_first = 32'(bb);
                end
            end
            rv.exp_pass = (rv.exp_err == 32'd0);
            run_vec(rv, 1'b1);
        end

        // Reset after two of five accepted beats, then a clean rerun.
        clear_faults();
        cur_seed = 32'h1;
        cur_cnst = 32'h2;
        cur_nb   = 5;
        @(posedge clk); #1;
        ctrl_seed = 32'h1;
        ctrl_constant = 32'h2;
        ctrl_num_beats = 32'd5;
        ctrl_tready_mask = 8'hFF;
        ctrl_start = 1'b1;
        b = 0;
        drive_beat(0);
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
        hs = 0;
        for (int k = 0; k < 20 && hs < 2; k++) begin
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            if (acc) hs++;
            @(posedge clk); #1;
            if (acc) begin
                b++;
                drive_beat(b);
            end
        end
        chk("pre_reset_handshakes", 32'(hs), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_tready", 32'(s_axis_tready), 32'd0);
        chk("midrst_busy", 32'(status_busy), 32'd0);
        chk("midrst_done", 32'(status_done), 32'd0);
        chk("midrst_beat_count", status_beat_count, 32'd0);
        chk("midrst_err_count", status_err_count, 32'd0);
        chk("midrst_first_err", status_first_err_beat, 32'hFFFF_FFFF);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        load_faults(tbl[0]);
        run_vec(tbl[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
